// File: rtl/addsub_pkg.sv
// Shared types and helpers for the add/sub accumulator front-end.
package addsub_pkg;

   // Datapath width of the add_sub_8bit core.
   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      OP_CLR  = 2'd0,
      OP_LOAD = 2'd1,
      OP_ADD  = 2'd2,
      OP_SUB  = 2'd3
   } op_t;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_EXEC = 1'b1
   } state_t;

   // Two's-complement overflow from the sign bits of A, B and the result.
   // Subtraction overflows when the operands differ in sign and the result
   // sign departs from A; addition when they agree and the result departs.
   function automatic logic ovf_detect(input logic i_sub,
                                       input logic i_a_msb,
                                       input logic i_b_msb,
                                       input logic i_r_msb);
      logic w_same;
      w_same = (i_a_msb == i_b_msb);
      if (i_sub)
         return !w_same && (i_r_msb != i_a_msb);
      else
         return w_same && (i_r_msb != i_a_msb);
   endfunction

endpackage

// File: rtl/add_sub_8bit.sv
// Combinational 8-bit adder/subtractor: Result = A + B, or A - B when
// Subtract is set. Wraps modulo 256.
module add_sub_8bit (
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic       Subtract,
   output logic [7:0] Result
);

   // Single adder with B conditionally inverted and carry-in for subtract.
   always_comb begin
      Result = A + (Subtract ? ~B : B) + {7'd0, Subtract};
   end

endmodule

// File: rtl/addsub_accumulator.sv
// Command front-end around add_sub_8bit: holds an accumulator fed back as
// operand A, accepts CLR/LOAD/ADD/SUB over valid/ready, and repeats ADD/SUB
// a programmable number of times. DATA_W must stay 8 to match the core.
module addsub_accumulator
   import addsub_pkg::*;
#(
   parameter int REP_W  = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic [REP_W-1:0]  cmd_rep,
   output logic [DATA_W-1:0] acc,
   output logic              zero,
   output logic              ovf,
   output logic              done
);

   localparam logic [REP_W-1:0] ONE_REP = {{(REP_W-1){1'b0}}, 1'b1};

   state_t              r_state;
   logic [DATA_W-1:0]   r_acc;
   logic [DATA_W-1:0]   r_opnd;
   logic                r_sub;
   logic [REP_W-1:0]    r_rem;
   logic                r_ovf;
   logic                r_done;

   state_t              w_state_cur;
   state_t              w_state_nxt;
   logic [DATA_W-1:0]   w_acc_nxt;
   logic [DATA_W-1:0]   w_opnd_nxt;
   logic                w_sub_nxt;
   logic [REP_W-1:0]    w_rem_nxt;
   logic                w_ovf_nxt;
   logic                w_done_nxt;
   logic                w_ready;
   logic [DATA_W-1:0]   w_result;
   logic                w_ovf_now;
   op_t                 w_op;

   add_sub_8bit u_core (
      .A        (r_acc),
      .B        (r_opnd),
      .Subtract (r_sub),
      .Result   (w_result)
   );

   assign w_op      = op_t'(cmd_op);
   assign w_ovf_now = ovf_detect(r_sub, r_acc[DATA_W-1], r_opnd[DATA_W-1],
                                 w_result[DATA_W-1]);

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_acc   <= '0;
         r_opnd  <= '0;
         r_sub   <= 1'b0;
         r_rem   <= '0;
         r_ovf   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_acc   <= w_acc_nxt;
         r_opnd  <= w_opnd_nxt;
         r_sub   <= w_sub_nxt;
         r_rem   <= w_rem_nxt;
         r_ovf   <= w_ovf_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Next-state and command decode; anything not EXEC behaves as IDLE.
   always_comb begin
      w_state_cur = (r_state == S_EXEC) ? S_EXEC : S_IDLE;
      w_state_nxt = w_state_cur;
      w_acc_nxt   = r_acc;
      w_opnd_nxt  = r_opnd;
      w_sub_nxt   = r_sub;
      w_rem_nxt   = r_rem;
      w_ovf_nxt   = r_ovf;
      w_done_nxt  = 1'b0;
      w_ready     = 1'b0;
      case (w_state_cur)
         S_EXEC: begin
            w_acc_nxt = w_result;
            w_ovf_nxt = r_ovf | w_ovf_now;
            w_rem_nxt = r_rem - ONE_REP;
            // <= 1 rather than == 1 so a corrupted zero count cannot spin.
            if (r_rem <= ONE_REP) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: begin
            w_ready = 1'b1;
            if (cmd_valid) begin
               w_ovf_nxt = 1'b0;
               case (w_op)
                  OP_CLR: begin
                     w_acc_nxt  = '0;
                     w_done_nxt = 1'b1;
                  end
                  OP_LOAD: begin
                     w_acc_nxt  = cmd_data;
                     w_done_nxt = 1'b1;
                  end
                  default: begin
                     w_opnd_nxt  = cmd_data;
                     w_sub_nxt   = (w_op == OP_SUB);
                     w_rem_nxt   = (cmd_rep == '0) ? ONE_REP : cmd_rep;
                     w_state_nxt = S_EXEC;
                  end
               endcase
            end
         end
      endcase
   end

   assign cmd_ready = w_ready;
   assign acc       = r_acc;
   assign zero      = (r_acc == '0);
   assign ovf       = r_ovf;
   assign done      = r_done;

endmodule

// File: tb/tb_addsub_accumulator.sv
// Scoreboard bench for addsub_accumulator: the driver queues the expected
// completion of every command, the monitor pops one entry per done pulse.
module tb_addsub_accumulator;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'd0;
   logic [7:0] cmd_data = 8'd0;
   logic [3:0] cmd_rep = 4'd0;
   logic [7:0] acc;
   logic       zero;
   logic       ovf;
   logic       done;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string      name;
      logic [7:0] acc;
      logic       ovf;
   } exp_t;

   exp_t exp_q[$];

   addsub_accumulator #(.REP_W(4), .DATA_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .cmd_rep   (cmd_rep),
      .acc       (acc),
      .zero      (zero),
      .ovf       (ovf),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, "_acc"},   {24'd0, acc}, {24'd0, e.acc});
            check({e.name, "_ovf"},   {31'd0, ovf}, {31'd0, e.ovf});
            check({e.name, "_zero"},  {31'd0, zero}, {31'd0, (e.acc == 8'd0)});
            check({e.name, "_ready"}, {31'd0, cmd_ready}, 32'd1);
         end
      end
   end

   // Present a command, hold it until accepted, return #1 after the accept
   // edge. waited counts the negedges spent with cmd_ready low.
   task automatic send(input string name, input logic [1:0] op,
                       input logic [7:0] data, input logic [3:0] rep,
                       input bit exp_done, input logic [7:0] exp_acc,
                       input logic exp_ovf, output int waited);
      exp_t e;
      waited = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      cmd_rep   = rep;
      while (!cmd_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 100) begin
         $display("FAIL %s_accept: cmd_ready stayed 0 expected 1", name);
         $fatal(1, "accept timeout");
      end
      if (exp_done) begin
         e.name = name;
         e.acc  = exp_acc;
         e.ovf  = exp_ovf;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check({name, "_drain"}, exp_q.size(), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time 2000000 expected completion earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;

      // Reset for two edges, then release.
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("rst_acc",   {24'd0, acc}, 32'd0);
      check("rst_zero",  {31'd0, zero}, 32'd1);
      check("rst_ovf",   {31'd0, ovf}, 32'd0);
      check("rst_done",  {31'd0, done}, 32'd0);
      check("rst_ready", {31'd0, cmd_ready}, 32'd1);

      // LOAD 50 then SUB 10 x4, watching every step.
      send("load50", 2'd1, 8'd50, 4'd0, 1'b1, 8'd50, 1'b0, w);
      send("sub10x4", 2'd3, 8'd10, 4'd4, 1'b1, 8'd10, 1'b0, w);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("sub10x4_busy%0d", k), {31'd0, cmd_ready}, 32'd0);
         check($sformatf("sub10x4_done%0d", k), {31'd0, done}, 32'd0);
         @(posedge clk);
         #1;
         check($sformatf("sub10x4_step%0d", k), {24'd0, acc}, 32'd40 - 32'd10 * k);
      end
      drain("sub10x4");

      // Signed overflow, wrap, and clearing of ovf by a new command.
      send("load70",  2'd1, 8'h70, 4'd0, 1'b1, 8'h70, 1'b0, w);
      send("add20",   2'd2, 8'h20, 4'd1, 1'b1, 8'h90, 1'b1, w);
      send("loadF0",  2'd1, 8'hF0, 4'd0, 1'b1, 8'hF0, 1'b0, w);
      send("add20w",  2'd2, 8'h20, 4'd1, 1'b1, 8'h10, 1'b0, w);
      send("load80",  2'd1, 8'h80, 4'd0, 1'b1, 8'h80, 1'b0, w);
      send("sub1ovf", 2'd3, 8'h01, 4'd1, 1'b1, 8'h7F, 1'b1, w);
      // Overflow on the first of three iterations must stay sticky.
      send("load70b", 2'd1, 8'h70, 4'd0, 1'b1, 8'h70, 1'b0, w);
      send("add10x3", 2'd2, 8'h10, 4'd3, 1'b1, 8'hA0, 1'b1, w);
      drain("ovf");

      // rep=0 runs exactly once and lands on zero.
      send("load5",  2'd1, 8'd5, 4'd0, 1'b1, 8'd5, 1'b0, w);
      send("sub5r0", 2'd3, 8'd5, 4'd0, 1'b1, 8'd0, 1'b0, w);
      drain("rep0");

      // Backpressure: LOAD held off until the ADD finishes.
      send("clr",     2'd0, 8'hAA, 4'd0, 1'b1, 8'd0,  1'b0, w);
      send("add11x3", 2'd2, 8'd11, 4'd3, 1'b1, 8'd33, 1'b0, w);
      send("load99",  2'd1, 8'd99, 4'd0, 1'b1, 8'd99, 1'b0, w);
      check("load99_wait", w, 32'd3);
      send("clr_b2b", 2'd0, 8'h55, 4'd0, 1'b1, 8'd0, 1'b0, w);
      check("clr_b2b_wait", w, 32'd0);
      drain("bp");

      // Reset on the third EXEC edge aborts without a done pulse.
      send("add1x15", 2'd2, 8'd1, 4'd15, 1'b0, 8'd0, 1'b0, w);
      @(posedge clk);
      @(posedge clk);
      #1;
      check("abort_mid_acc", {24'd0, acc}, 32'd2);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("abort_acc",   {24'd0, acc}, 32'd0);
      check("abort_done",  {31'd0, done}, 32'd0);
      check("abort_ready", {31'd0, cmd_ready}, 32'd1);
      check("abort_zero",  {31'd0, zero}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      send("load7", 2'd1, 8'd7, 4'd0, 1'b1, 8'd7, 1'b0, w);
      drain("post_abort");

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
